// File: rtl/mem_req_arbiter.sv
// Round-robin arbiter/sequencer for the I-cache (port 0) and D-cache (port 1) in front of the
// single-ported block memory. Define MEM_TIMEOUT_EN to add a read watchdog that flags err.
module mem_req_arbiter #(
  parameter int BLOCK_SIZE     = 256,
  parameter int ADDR_WIDTH     = 16,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req0,
  input  logic                  req1,
  input  logic                  we0,
  input  logic                  we1,
  input  logic [ADDR_WIDTH-1:0] addr0,
  input  logic [ADDR_WIDTH-1:0] addr1,
  input  logic [BLOCK_SIZE-1:0] wdata0,
  input  logic [BLOCK_SIZE-1:0] wdata1,
  output logic                  gnt0,
  output logic                  gnt1,
  output logic                  done0,
  output logic                  done1,
  output logic [BLOCK_SIZE-1:0] rdata,
  output logic                  err,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_w_addr,
  output logic [ADDR_WIDTH-1:0] mem_r_addr,
  output logic [BLOCK_SIZE-1:0] mem_block,
  input  logic                  mem_block_ready,
  input  logic                  mem_fifo_full,
  input  logic [BLOCK_SIZE-1:0] mem_q
);

  // state    | meaning
  // IDLE     | arbitrate pending requests
  // WRITE    | issue mem_we once the write fifo has room
  // RD_ISSUE | present read address; memory may still show stale block_ready
  // RD_WAIT  | wait for block_ready, capture mem_q
  // DONE     | done pulse is out, return to IDLE
  typedef enum logic [2:0] {IDLE, WRITE, RD_ISSUE, RD_WAIT, DONE} state_t;

  state_t                state_q, state_d;
  logic                  last_q, last_d;
  logic                  port_q, port_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [BLOCK_SIZE-1:0] wdata_q, wdata_d;
  logic                  gnt0_q, gnt0_d, gnt1_q, gnt1_d;
  logic                  done0_q, done0_d, done1_q, done1_d;
  logic                  err_q, err_d;
  logic                  mem_we_q, mem_we_d;
  logic [ADDR_WIDTH-1:0] mem_w_addr_q, mem_w_addr_d;
  logic [ADDR_WIDTH-1:0] mem_r_addr_q, mem_r_addr_d;
  logic [BLOCK_SIZE-1:0] rdata_q, rdata_d;
  logic [BLOCK_SIZE-1:0] mem_block_q, mem_block_d;
  logic                  win;
  logic                  win_we;
  logic [ADDR_WIDTH-1:0] win_addr;
  logic [BLOCK_SIZE-1:0] win_data;
`ifdef MEM_TIMEOUT_EN
  localparam int TMO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  logic [TMO_W-1:0]      tmo_q, tmo_d;
`endif

  // On a tie the port that was not served last wins.
  always_comb begin
    win      = (req0 && req1) ? ~last_q : req1;
    win_we   = win ? we1 : we0;
    win_addr = win ? addr1 : addr0;
    win_data = win ? wdata1 : wdata0;
  end

  always_comb begin
    state_d      = state_q;
    last_d       = last_q;
    port_d       = port_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    gnt0_d       = 1'b0;
    gnt1_d       = 1'b0;
    done0_d      = 1'b0;
    done1_d      = 1'b0;
    err_d        = 1'b0;
    mem_we_d     = 1'b0;
    mem_w_addr_d = mem_w_addr_q;
    mem_r_addr_d = mem_r_addr_q;
    mem_block_d  = mem_block_q;
    rdata_d      = rdata_q;
`ifdef MEM_TIMEOUT_EN
    tmo_d        = tmo_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (req0 || req1) begin
          last_d  = win;
          port_d  = win;
          addr_d  = win_addr;
          wdata_d = win_data;
          gnt0_d  = ~win;
          gnt1_d  = win;
          if (win_we) begin
            state_d = WRITE;
            if (!mem_fifo_full) begin
              mem_we_d     = 1'b1;
              mem_w_addr_d = win_addr;
              mem_block_d  = win_data;
            end
          end else begin
            state_d      = RD_ISSUE;
            mem_r_addr_d = win_addr;
`ifdef MEM_TIMEOUT_EN
            tmo_d        = TMO_W'(TIMEOUT_CYCLES - 1);
`endif
          end
        end
      end
      WRITE: begin
        if (mem_we_q) begin
          state_d = DONE;
          done0_d = ~port_q;
          done1_d = port_q;
        end else if (!mem_fifo_full) begin
          mem_we_d     = 1'b1;
          mem_w_addr_d = addr_q;
          mem_block_d  = wdata_q;
        end
      end
      RD_ISSUE: state_d = RD_WAIT;
      RD_WAIT: begin
        if (mem_block_ready) begin
          state_d = DONE;
          rdata_d = mem_q;
          done0_d = ~port_q;
          done1_d = port_q;
        end
`ifdef MEM_TIMEOUT_EN
        else if (tmo_q == '0) begin
          state_d = DONE;
          rdata_d = '0;
          err_d   = 1'b1;
          done0_d = ~port_q;
          done1_d = port_q;
        end else begin
          tmo_d = tmo_q - TMO_W'(1);
        end
`endif
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      last_q       <= 1'b1;
      port_q       <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      gnt0_q       <= 1'b0;
      gnt1_q       <= 1'b0;
      done0_q      <= 1'b0;
      done1_q      <= 1'b0;
      err_q        <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_w_addr_q <= '0;
      mem_r_addr_q <= '0;
      mem_block_q  <= '0;
      rdata_q      <= '0;
`ifdef MEM_TIMEOUT_EN
      tmo_q        <= '0;
`endif
    end else begin
      state_q      <= state_d;
      last_q       <= last_d;
      port_q       <= port_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      gnt0_q       <= gnt0_d;
      gnt1_q       <= gnt1_d;
      done0_q      <= done0_d;
      done1_q      <= done1_d;
      err_q        <= err_d;
      mem_we_q     <= mem_we_d;
      mem_w_addr_q <= mem_w_addr_d;
      mem_r_addr_q <= mem_r_addr_d;
      mem_block_q  <= mem_block_d;
      rdata_q      <= rdata_d;
`ifdef MEM_TIMEOUT_EN
      tmo_q        <= tmo_d;
`endif
    end
  end

  assign gnt0       = gnt0_q;
  assign gnt1       = gnt1_q;
  assign done0      = done0_q;
  assign done1      = done1_q;
  assign err        = err_q;
  assign rdata      = rdata_q;
  assign mem_we     = mem_we_q;
  assign mem_w_addr = mem_w_addr_q;
  assign mem_r_addr = mem_r_addr_q;
  assign mem_block  = mem_block_q;

endmodule

// File: tb/tb_mem_req_arbiter.sv
// Bench for mem_req_arbiter: directed scenarios plus random traffic against a transaction-level
// timing model with a shadow memory; define MEM_TIMEOUT_EN to also cover the read watchdog.
`timescale 1ns/1ps
module tb_mem_req_arbiter;
  localparam int BS  = 256;
  localparam int AW  = 16;
  localparam int TMO = 8;
  localparam int INT_MAX = 32'h7fff_ffff;

  logic          clk = 1'b0;
  logic          rst, req0, req1, we0, we1;
  logic [AW-1:0] addr0, addr1;
  logic [BS-1:0] wdata0, wdata1;
  logic          gnt0, gnt1, done0, done1, err, mem_we;
  logic [BS-1:0] rdata, mem_block, mem_q;
  logic [AW-1:0] mem_w_addr, mem_r_addr;
  logic          mem_block_ready, mem_fifo_full;

  mem_req_arbiter #(.BLOCK_SIZE(BS), .ADDR_WIDTH(AW), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .rst(rst), .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1), .rdata(rdata), .err(err),
    .mem_we(mem_we), .mem_w_addr(mem_w_addr), .mem_r_addr(mem_r_addr), .mem_block(mem_block),
    .mem_block_ready(mem_block_ready), .mem_fifo_full(mem_fifo_full), .mem_q(mem_q)
  );

  always #5 clk = ~clk;

  // Memory behaviour: 8 blocks, write on the clock, read data follows the read address.
  logic          mem_clr = 1'b1;
  logic [BS-1:0] mem_arr [8];
  always @(posedge clk) begin
    if (mem_clr) begin
      for (int i = 0; i < 8; i++) mem_arr[i] <= '0;
    end else if (mem_we) begin
      mem_arr[mem_w_addr[2:0]] <= mem_block;
    end
  end
  assign mem_q = mem_arr[mem_r_addr[2:0]];

  int n_chk = 0;
  int n_pass = 0;
  int cyc = 0;

  task automatic check_eq(input string tag, input logic [BS-1:0] got, input logic [BS-1:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h required %h (edge %0d)", tag, got, exp, cyc);
  endtask

  // Reference model: tracks one outstanding transaction by edge timestamps.
  logic [BS-1:0] ref_mem [8];
  bit            m_busy, m_last, m_port, m_we, m_wr_pend, m_reading;
  int            m_rd_from, m_done_at, m_free_at;
  logic [AW-1:0] m_addr;
  logic [BS-1:0] m_data;
  logic          e_gnt0, e_gnt1, e_done0, e_done1, e_we, e_err;
  logic [BS-1:0] e_rdata, e_block;
  logic [AW-1:0] e_waddr, e_raddr;

  task automatic model_edge();
    int k;
    k = cyc;
    e_gnt0 = 0; e_gnt1 = 0; e_done0 = 0; e_done1 = 0; e_we = 0; e_err = 0;
    if (rst) begin
      m_busy = 0; m_last = 1; m_wr_pend = 0; m_reading = 0; m_done_at = -1;
      e_rdata = '0; e_block = '0; e_waddr = '0; e_raddr = '0;
    end else begin
      if (m_busy && k >= m_free_at) m_busy = 0;
      if (!m_busy && (req0 || req1)) begin
        if (req0 && req1) m_port = ~m_last;
        else m_port = req1;
        m_last = m_port;
        m_busy = 1; m_done_at = -1; m_free_at = INT_MAX;
        m_we   = m_port ? we1 : we0;
        m_addr = m_port ? addr1 : addr0;
        m_data = m_port ? wdata1 : wdata0;
        if (m_port) e_gnt1 = 1; else e_gnt0 = 1;
        if (m_we) m_wr_pend = 1;
        else begin
          m_reading = 1; m_rd_from = k + 2; e_raddr = m_addr;
        end
      end
      if (m_busy) begin
        if (m_wr_pend && !mem_fifo_full) begin
          e_we = 1; e_waddr = m_addr; e_block = m_data;
          ref_mem[m_addr[2:0]] = m_data;
          m_wr_pend = 0; m_done_at = k + 1;
        end else if (m_reading && k >= m_rd_from && mem_block_ready) begin
          e_rdata = ref_mem[m_addr[2:0]]; m_reading = 0; m_done_at = k;
        end
`ifdef MEM_TIMEOUT_EN
        else if (m_reading && k == m_rd_from + TMO - 1) begin
          e_rdata = '0; e_err = 1; m_reading = 0; m_done_at = k;
        end
`endif
        if (k == m_done_at) begin
          if (m_port) e_done1 = 1; else e_done0 = 1;
          m_free_at = k + 2;
        end
      end
    end
  endtask

  task automatic compare();
    check_eq("gnt0", BS'(gnt0), BS'(e_gnt0));
    check_eq("gnt1", BS'(gnt1), BS'(e_gnt1));
    check_eq("done0", BS'(done0), BS'(e_done0));
    check_eq("done1", BS'(done1), BS'(e_done1));
    check_eq("mem_we", BS'(mem_we), BS'(e_we));
    check_eq("err", BS'(err), BS'(e_err));
    check_eq("rdata", rdata, e_rdata);
    check_eq("mem_w_addr", BS'(mem_w_addr), BS'(e_waddr));
    check_eq("mem_block", mem_block, e_block);
    check_eq("mem_r_addr", BS'(mem_r_addr), BS'(e_raddr));
  endtask

  task automatic step();
    @(posedge clk);
    cyc++;
    @(negedge clk);
    model_edge();
    compare();
  endtask

  task automatic wait_gnt(input bit port, input int limit, output int n);
    n = 0;
    do begin step(); n++; end while (!(port ? gnt1 : gnt0) && n < limit);
    check_eq("gnt_seen", BS'(port ? gnt1 : gnt0), BS'(1));
  endtask

  task automatic wait_done(input bit port, input int limit, output int n);
    n = 0;
    do begin step(); n++; end while (!(port ? done1 : done0) && n < limit);
    check_eq("done_seen", BS'(port ? done1 : done0), BS'(1));
  endtask

  function automatic logic [BS-1:0] rand_blk();
    logic [BS-1:0] b;
    for (int i = 0; i < BS / 32; i++) b[i*32 +: 32] = $urandom();
    return b;
  endfunction

  initial begin
    int n;
    int order[$];
    logic [BS-1:0] fa;
    fa = {32{8'hFA}};
    rst = 1; req0 = 0; req1 = 0; we0 = 0; we1 = 0;
    addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
    mem_fifo_full = 0; mem_block_ready = 0;
    for (int i = 0; i < 8; i++) ref_mem[i] = '0;
    repeat (3) step();
    mem_clr = 0; rst = 0;

    // Write 0xFA.. to block 3 from port 0
    req0 = 1; we0 = 1; addr0 = 16'h0003; wdata0 = fa;
    step();
    check_eq("wr_gnt0", BS'(gnt0), BS'(1));
    check_eq("wr_mem_we", BS'(mem_we), BS'(1));
    check_eq("wr_addr", BS'(mem_w_addr), BS'(16'h0003));
    req0 = 0;
    wait_done(0, 10, n);
    check_eq("wr_done_lat", BS'(n), BS'(1));
    check_eq("wr_err", BS'(err), BS'(0));

    // Port 1 reads block 3 with a 10-cycle memory latency
    req1 = 1; we1 = 0; addr1 = 16'h0003;
    wait_gnt(1, 10, n);
    req1 = 0;
    check_eq("rd_raddr", BS'(mem_r_addr), BS'(16'h0003));
    repeat (10) step();
    mem_block_ready = 1;
    wait_done(1, 10, n);
    check_eq("rd_done_lat", BS'(n), BS'(1));
    check_eq("rd_data", rdata, fa);
    mem_block_ready = 0;

    // Simultaneous reads after reset, twice: port 0 first both times
    rst = 1; step(); rst = 0;
    mem_block_ready = 1;
    repeat (2) begin
      order = {};
      req0 = 1; we0 = 0; addr0 = 16'h0001; req1 = 1; we1 = 0; addr1 = 16'h0002;
      for (int c = 0; c < 40 && (req0 || req1); c++) begin
        step();
        if (gnt0) begin order.push_back(0); req0 = 0; end
        if (gnt1) begin order.push_back(1); req1 = 0; end
      end
      check_eq("rr_count", BS'(order.size()), BS'(2));
      if (order.size() == 2) begin
        check_eq("rr_first", BS'(order[0]), BS'(0));
        check_eq("rr_second", BS'(order[1]), BS'(1));
      end
      wait_done(1, 40, n);
    end
    mem_block_ready = 0;

    // Write under fifo backpressure for 5 edges
    step();
    mem_fifo_full = 1; req0 = 1; we0 = 1; addr0 = 16'h0005; wdata0 = rand_blk();
    wait_gnt(0, 10, n);
    req0 = 0;
    check_eq("bp_no_we", BS'(mem_we), BS'(0));
    repeat (4) begin
      step();
      check_eq("bp_no_we", BS'(mem_we), BS'(0));
    end
    mem_fifo_full = 0;
    step();
    check_eq("bp_we", BS'(mem_we), BS'(1));
    step();
    check_eq("bp_done", BS'(done0), BS'(1));

    // Reset while waiting for read data; held req0 is granted afterwards
    req0 = 1; we0 = 0; addr0 = 16'h0003;
    wait_gnt(0, 10, n);
    req0 = 0;
    repeat (3) step();
    req0 = 1; rst = 1;
    step();
    check_eq("rst_done0", BS'(done0), BS'(0));
    check_eq("rst_rdata", rdata, '0);
    rst = 0;
    step();
    check_eq("post_rst_gnt0", BS'(gnt0), BS'(1));
    req0 = 0; mem_block_ready = 1;
    wait_done(0, 10, n);
    mem_block_ready = 0;

`ifdef MEM_TIMEOUT_EN
    // Memory never ready: watchdog completes the read with err
    req1 = 1; we1 = 0; addr1 = 16'h0003;
    wait_gnt(1, 10, n);
    req1 = 0;
    wait_done(1, 20, n);
    check_eq("tmo_lat", BS'(n), BS'(TMO + 1));
    check_eq("tmo_err", BS'(err), BS'(1));
    check_eq("tmo_rdata", rdata, '0);
`endif

    // Random traffic
    for (int c = 0; c < 3000; c++) begin
      if (gnt0) req0 = 0;
      if (gnt1) req1 = 0;
      if (!req0 && $urandom_range(3) == 0) begin
        req0 = 1; we0 = 1'($urandom_range(1)); addr0 = AW'($urandom_range(7)); wdata0 = rand_blk();
      end
      if (!req1 && $urandom_range(3) == 0) begin
        req1 = 1; we1 = 1'($urandom_range(1)); addr1 = AW'($urandom_range(7)); wdata1 = rand_blk();
      end
      mem_fifo_full   = ($urandom_range(3) == 0);
      mem_block_ready = ($urandom_range(2) == 0);
      rst             = ($urandom_range(299) == 0);
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/mem_req_arbiter.md
Name: mem_req_arbiter

Overview:
- Round-robin arbiter and sequencer placing two cache requesters in front of the single-ported main memory block.
- Port 0 = instruction cache, port 1 = data cache.
- Serialises block reads and writes, drives the memory's read/write address and write-enable, and waits on the memory's block_ready.
- Returns each read block to the granted requester with a one-cycle done pulse.

Parameters:
- BLOCK_SIZE, 256, block width in bits
- ADDR_WIDTH, 16, block address width
- TIMEOUT_CYCLES, 64, watchdog limit for reads (used only with the optional feature)

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- req0, req1  in  1  request; held high until the matching gnt
- we0, we1  in  1  1 = write block, 0 = read block
- addr0, addr1  in  ADDR_WIDTH  block address
- wdata0, wdata1  in  BLOCK_SIZE  write block
- gnt0, gnt1  out  1  one-cycle pulse: request accepted and latched
- done0, done1  out  1  one-cycle pulse: operation complete; rdata valid if read
- rdata  out  BLOCK_SIZE  read block, shared; valid with done
- err  out  1  valid with done; 0 unless MEM_TIMEOUT_EN
- mem_we  out  1  memory write enable
- mem_w_addr  out  ADDR_WIDTH  memory write address
- mem_r_addr  out  ADDR_WIDTH  memory read address
- mem_block  out  BLOCK_SIZE  memory write data
- mem_block_ready  in  1  memory read data stable
- mem_fifo_full  in  1  memory cannot accept a write
- mem_q  in  BLOCK_SIZE  memory read data

Behaviour:
- All outputs registered.
- Reset values:
  - gnt*, done*, err, mem_we = 0
  - rdata, mem_block, mem_w_addr = 0
  - mem_r_addr = 0
  - state = IDLE
  - round-robin pointer last = 1, so port 0 wins first.
- FSM states: IDLE, WRITE, RD_ISSUE, RD_WAIT, DONE.
- IDLE:
  - If any req is high, pick a winner:
    - only one req high: that port wins.
    - both high: the port != last wins.
  - Latch the winner's we/addr/wdata and set last = winner.
  - Pulse gnt_winner in the next cycle.
  - Next state: WRITE if we, else RD_ISSUE.
- req inputs are ignored outside IDLE. A losing request stays pending and is taken on the next IDLE.
- WRITE:
  - Drive mem_w_addr and mem_block.
  - mem_we = 1 for exactly one cycle, only while mem_fifo_full = 0.
  - If mem_fifo_full = 1, stay in WRITE with mem_we = 0.
  - Next state: DONE.
- RD_ISSUE: drive mem_r_addr = latched addr for one cycle, then go to RD_WAIT. The memory is allowed one cycle to drop block_ready.
- RD_WAIT:
  - Stay while mem_block_ready = 0.
  - When mem_block_ready = 1 is sampled, capture rdata <= mem_q and go to DONE.
- DONE: done_winner = 1 for one cycle, then IDLE. Back-to-back grants are possible from the following IDLE cycle.
- mem_r_addr holds its last value outside reads. The memory sees an address change only on RD_ISSUE.
- Latency, with req sampled in IDLE at cycle N:
  - Write, no backpressure: gnt at N+1, mem_we at N+1, done at N+2.
  - Read: gnt at N+1, done at (first cycle ≥ N+2 with mem_block_ready sampled high) + 1.
- Exactly one gnt and one done per accepted request. gnt0 and gnt1 are never both high; likewise done0 and done1.
- Reset mid-operation: abandon the operation with no done and no mem_we, and return to IDLE. A pending req is re-arbitrated normally after reset.
- A write and a read to the same address are strictly ordered by grant order. A read after a write observes the written data.

Optional Feature:
- Macro: MEM_TIMEOUT_EN.
- Defined:
  - A counter runs in RD_WAIT. If it reaches TIMEOUT_CYCLES without mem_block_ready, go to DONE with rdata = 0 and err = 1 alongside done.
  - The counter clears on entry to RD_ISSUE.
- Undefined: RD_WAIT waits indefinitely and err is tied to 0.

Test Plan:
- Reset, then req0 write, addr 0x0003, wdata all-0xFA -> gnt0 one cycle later, mem_we = 1 for one cycle with mem_w_addr = 0x0003, done0 the next cycle, err = 0.
- req1 read of 0x0003, memory model with 10-cycle latency -> gnt1 pulse; mem_r_addr = 0x0003; done1 exactly 1 cycle after block_ready is sampled high; rdata = all-0xFA.
- req0 and req1 reads asserted in the same cycle after reset -> port 0 served first, then port 1. Repeat the simultaneous request -> port 0 served first again (last = 1). Never two gnts in one cycle.
- Write with mem_fifo_full held high for 5 cycles -> no mem_we during those cycles, mem_we pulses on the first cycle fifo_full = 0, done one cycle later.
- Assert rst during RD_WAIT -> no done, all outputs at reset values. A held req0 is then granted normally.
- With MEM_TIMEOUT_EN and TIMEOUT_CYCLES = 8, memory never ready -> done with err = 1 and rdata = 0 after 8 RD_WAIT cycles.
